// File: rtl/bip_multicycle_cpu.sv
// Multi-cycle accumulator CPU with request/acknowledge data-memory handshake.
// Define BIP_LOGIC_OPS_EN to build the logic/shift opcodes (8-15).
module bip_multicycle_cpu #(
    parameter int ADDR_LENGTH        = 11,
    parameter int DATA_LENGTH        = 16,
    parameter int OPCODE_LENGTH      = 5,
    parameter int OPERAND_LENGTH     = 11,
    parameter int INSTRUCTION_LENGTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INSTRUCTION_LENGTH-1:0] instruction,
    input  logic [DATA_LENGTH-1:0]        data_from_dm,
    input  logic                          dm_ack,
    output logic [DATA_LENGTH-1:0]        data_to_dm,
    output logic [ADDR_LENGTH-1:0]        addr_to_pm,
    output logic [ADDR_LENGTH-1:0]        addr_to_dm,
    output logic [DATA_LENGTH-1:0]        outPC,
    output logic                          RdRam,
    output logic                          WrRam,
    output logic                          halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [OPCODE_LENGTH-1:0] OP_HLT  = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OP_STO  = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_LD   = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_LDI  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = OPCODE_LENGTH'(7);
`ifdef BIP_LOGIC_OPS_EN
    localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(8);
    localparam logic [OPCODE_LENGTH-1:0] OP_ANDI = OPCODE_LENGTH'(9);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(10);
    localparam logic [OPCODE_LENGTH-1:0] OP_ORI  = OPCODE_LENGTH'(11);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(12);
    localparam logic [OPCODE_LENGTH-1:0] OP_XORI = OPCODE_LENGTH'(13);
    localparam logic [OPCODE_LENGTH-1:0] OP_SHL  = OPCODE_LENGTH'(14);
    localparam logic [OPCODE_LENGTH-1:0] OP_SHR  = OPCODE_LENGTH'(15);
`endif
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = OPCODE_LENGTH'(16);
    localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = OPCODE_LENGTH'(17);
    localparam logic [OPCODE_LENGTH-1:0] OP_JMP  = OPCODE_LENGTH'(18);
    localparam logic [OPCODE_LENGTH-1:0] OP_BLT  = OPCODE_LENGTH'(19);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [ADDR_LENGTH-1:0]          r_pc;
    logic [ADDR_LENGTH-1:0]          w_pc_nxt;
    logic [DATA_LENGTH-1:0]          r_acc;
    logic [DATA_LENGTH-1:0]          w_acc_nxt;
    logic [INSTRUCTION_LENGTH-1:0]   r_ir;
    logic [INSTRUCTION_LENGTH-1:0]   w_ir_nxt;

    logic [OPCODE_LENGTH-1:0]        w_opcode;
    logic [OPERAND_LENGTH-1:0]       w_operand;
    logic signed [OPERAND_LENGTH-1:0] w_operand_s;
    logic [DATA_LENGTH-1:0]          w_imm;
    logic [ADDR_LENGTH-1:0]          w_target;
    logic [ADDR_LENGTH-1:0]          w_pc_inc;
`ifdef BIP_LOGIC_OPS_EN
    logic [OPERAND_LENGTH-1:0]       w_shamt;
`endif

    logic                            w_halt;
    logic                            w_mem_rd;
    logic                            w_mem_wr;
    logic                            w_take;
    logic [DATA_LENGTH-1:0]          w_exec_acc;
    logic [DATA_LENGTH-1:0]          w_mem_acc;

    assign w_opcode    = r_ir[INSTRUCTION_LENGTH-1 -: OPCODE_LENGTH];
    assign w_operand   = r_ir[OPERAND_LENGTH-1:0];
    assign w_operand_s = w_operand;
    assign w_imm       = DATA_LENGTH'(w_operand_s);
    assign w_target    = w_operand[ADDR_LENGTH-1:0];
    assign w_pc_inc    = r_pc + ADDR_LENGTH'(1);
`ifdef BIP_LOGIC_OPS_EN
    assign w_shamt     = w_operand % OPERAND_LENGTH'(DATA_LENGTH);
`endif

    // Decode: EXEC-cycle result for register ops, MEM-cycle result for reads.
    always_comb begin
        w_halt     = 1'b0;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_take     = 1'b0;
        w_exec_acc = r_acc;
        w_mem_acc  = r_acc;
        case (w_opcode)
            OP_HLT:  w_halt = 1'b1;
            OP_STO:  w_mem_wr = 1'b1;
            OP_LD: begin
                w_mem_rd  = 1'b1;
                w_mem_acc = data_from_dm;
            end
            OP_LDI:  w_exec_acc = w_imm;
            OP_ADD: begin
                w_mem_rd  = 1'b1;
                w_mem_acc = r_acc + data_from_dm;
            end
            OP_ADDI: w_exec_acc = r_acc + w_imm;
            OP_SUB: begin
                w_mem_rd  = 1'b1;
                w_mem_acc = r_acc - data_from_dm;
            end
            OP_SUBI: w_exec_acc = r_acc - w_imm;
`ifdef BIP_LOGIC_OPS_EN
            OP_AND: begin
                w_mem_rd  = 1'b1;
                w_mem_acc = r_acc & data_from_dm;
            end
            OP_ANDI: w_exec_acc = r_acc & w_imm;
            OP_OR: begin
                w_mem_rd  = 1'b1;
                w_mem_acc = r_acc | data_from_dm;
            end
            OP_ORI:  w_exec_acc = r_acc | w_imm;
            OP_XOR: begin
                w_mem_rd  = 1'b1;
                w_mem_acc = r_acc ^ data_from_dm;
            end
            OP_XORI: w_exec_acc = r_acc ^ w_imm;
            OP_SHL:  w_exec_acc = r_acc << w_shamt;
            OP_SHR:  w_exec_acc = r_acc >> w_shamt;
`endif
            OP_BEQ:  w_take = (r_acc == '0);
            OP_BNE:  w_take = (r_acc != '0);
            OP_JMP:  w_take = 1'b1;
            OP_BLT:  w_take = r_acc[DATA_LENGTH-1];
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_acc_nxt   = r_acc;
        w_ir_nxt    = r_ir;
        unique case (r_state)
            S_FETCH: begin
                w_ir_nxt    = instruction;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_halt) begin
                    w_state_nxt = S_HALT;
                end else if (w_mem_rd || w_mem_wr) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_acc_nxt   = w_exec_acc;
                    w_pc_nxt    = w_take ? w_target : w_pc_inc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                if (dm_ack) begin
                    if (w_mem_rd) begin
                        w_acc_nxt = w_mem_acc;
                    end
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: ;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_acc   <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_acc   <= w_acc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    assign data_to_dm = r_acc;
    assign addr_to_pm = r_pc;
    assign addr_to_dm = w_target;
    assign outPC      = DATA_LENGTH'(r_pc);
    assign RdRam      = (r_state == S_MEM) && w_mem_rd;
    assign WrRam      = (r_state == S_MEM) && w_mem_wr;
    assign halted     = (r_state == S_HALT);

endmodule

// File: doc/bip_multicycle_cpu.md
Name: bip_multicycle_cpu

Overview:
- Parametrised successor to the single-cycle accumulator CPU: same accumulator ISA family (5-bit opcode, 11-bit operand), widened and extended.
- Multi-cycle FSM core with a data-memory request/acknowledge handshake (variable-latency RAM), conditional branches, immediate sign-extension and a halt state.
- Sits between program memory (combinational read) and data memory in the top-level.

Parameters:
- ADDR_LENGTH, 11, PC and data-address width; must be <= OPERAND_LENGTH.
- DATA_LENGTH, 16, accumulator and data-bus width; must be >= OPERAND_LENGTH.
- OPCODE_LENGTH, 5, opcode field width (instruction MSBs).
- OPERAND_LENGTH, 11, operand field width (instruction LSBs).
- INSTRUCTION_LENGTH, 16, must equal OPCODE_LENGTH+OPERAND_LENGTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- instruction  input  INSTRUCTION_LENGTH  program-memory word at addr_to_pm, valid in the same cycle.
- data_from_dm  input  DATA_LENGTH  read data; valid when dm_ack=1 during a read.
- dm_ack  input  1  data-memory completion strobe.
- data_to_dm  output  DATA_LENGTH  accumulator value (write data).
- addr_to_pm  output  ADDR_LENGTH  PC.
- addr_to_dm  output  ADDR_LENGTH  operand[ADDR_LENGTH-1:0] of the latched IR.
- outPC  output  DATA_LENGTH  PC zero-extended.
- RdRam  output  1  read request.
- WrRam  output  1  write request.
- halted  output  1  high in HALT state.

Behaviour:
- Reset (reset=0, immediate): PC=0, ACC=0, IR=0, state=FETCH, RdRam=WrRam=halted=0.
- Opcodes (decimal):
  - 0 HLT; 1 STO; 2 LD; 3 LDI; 4 ADD; 5 ADDI; 6 SUB; 7 SUBI.
  - 8 AND; 9 ANDI; 10 OR; 11 ORI; 12 XOR; 13 XORI; 14 SHL imm; 15 SHR imm (logical).
  - 16 BEQ; 17 BNE; 18 JMP; 19 BLT.
  - Others: NOP.
- Immediates are sign-extended from OPERAND_LENGTH to DATA_LENGTH. Shift amount = operand mod DATA_LENGTH.
- ADD/SUB wrap modulo 2^DATA_LENGTH; no carry out.
- FSM:
  - FETCH: IR <= instruction; go EXEC. 1 cycle.
  - EXEC, HLT: go HALT.
  - EXEC, STO/LD/ADD/SUB/AND/OR/XOR: go MEM.
  - EXEC, immediate/ALU-imm/NOP: ACC updated, PC <= PC+1, go FETCH.
  - EXEC, branches: PC <= operand if the condition holds, else PC+1; go FETCH.
    - BEQ: ACC==0.
    - BNE: ACC!=0.
    - BLT: ACC MSB=1.
    - JMP: always.
  - MEM: RdRam (loads/ALU-mem) or WrRam (STO) held high, addr_to_dm stable, until the cycle dm_ack=1.
    - In that cycle, reads compute ACC from data_from_dm; STO commits.
    - PC <= PC+1; go FETCH.
    - Requests drop the next cycle.
  - HALT: all requests 0, halted=1, PC frozen at the HLT address; exit only by reset.
- Latency: non-memory instruction = 2 cycles. Memory instruction = 2 + N cycles, where N>=1 is the cycle count until dm_ack.
- RdRam and WrRam are never high simultaneously and are never high outside MEM.
- dm_ack outside MEM is ignored.
- PC wraps from 2^ADDR_LENGTH-1 to 0.
- Branch condition uses ACC as registered before EXEC.
- data_to_dm = ACC at all times.

Optional Feature:
- Macro: BIP_LOGIC_OPS_EN.
- Defined: opcodes 8-15 behave as specified above.
- Undefined: opcodes 8-15 decode as NOP (PC+1, ACC unchanged, no memory request); logic/shift datapath is not synthesised.

Test Plan:
- Reset mid-MEM (RdRam=1, dm_ack withheld), assert reset=0 -> RdRam=0, PC=0, ACC=0 immediately; after release, fetch from address 0.
- Program LDI 5; ADDI -3; STO 7; HLT, with dm_ack 1 cycle after request -> WrRam asserted with addr_to_dm=7 and data_to_dm=2; halted=1 at PC=3; total cycles 2+2+3+2.
- LD 4 with dm_ack delayed 4 cycles, mem[4]=16'h8001 -> RdRam high exactly 4 cycles; ACC=16'h8001 afterwards.
- Loop LDI 3; SUBI 1; BNE 1; HLT -> BNE taken twice, falls through when ACC=0; halted at PC=3.
- With BIP_LOGIC_OPS_EN: LDI 16'h00F0-equivalent (LDI 240); XORI 255; SHL 4 -> ACC=16'h00F0. Without the macro: ACC stays 240 and PC advances by 3.
- JMP 2047 then the word at 2047 = ADDI 1 -> PC wraps to 0 after executing it.
